// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl: buffers received UART bytes in a small FIFO and launches
// the transmitter one byte at a time, following its busy handshake.
// Ports: clk, rst (synchronous, active high), enable (gates new launches),
//   rx_data/rx_valid (received byte strobe), tx_busy (transmitter busy),
//   tx_data/tx_start (launch to transmitter), fifo_count (bytes buffered),
//   overflow (sticky drop flag), overflow_clr (clears overflow).
// Optional: define UART_ECHO_CRLF_EN to append an LF after every accepted CR.
module uart_echo_ctrl #(
    parameter int DEPTH        = 4,
    parameter int ADDR_W       = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    input  logic              overflow_clr
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int TO_W  = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [TO_W-1:0]   to_cnt;
    logic [TO_W-1:0]   to_cnt_nx;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic              pop;
    logic              full;
    logic              push_req;
    logic              push_ok;
    logic              rx_lost;
    logic              drop;
    logic [7:0]        push_byte;

`ifdef UART_ECHO_CRLF_EN
    logic              lf_pend;
`endif

    // The only pop is the LAUNCH cycle; LAUNCH is entered only with
    // fifo_count != 0, so the FIFO can never underflow.
    assign pop  = (state == LAUNCH);
    assign full = (fifo_count == FULL_CNT);

    // Select what is offered to the FIFO this cycle. A pending LF takes
    // the write slot; a receive arriving in that same cycle is lost.
    always_comb begin
        push_req  = rx_valid;
        push_byte = rx_data;
        rx_lost   = 1'b0;
`ifdef UART_ECHO_CRLF_EN
        if (lf_pend) begin
            push_req  = 1'b1;
            push_byte = 8'h0A;
            rx_lost   = rx_valid;
        end
`endif
    end

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok = push_req && (!full || pop);
    assign drop    = (push_req && !push_ok) || rx_lost;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            tx_data    <= 8'h00;
            tx_start   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + ADDR_W'(1);
                tx_data <= mem[rd_ptr];
            end
            fifo_count <= fifo_count + CNT_W'(push_ok) - CNT_W'(pop);
            tx_start   <= pop;
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset. When full with a simultaneous push/pop the
    // write lands on the slot being read; the read sees the old byte.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= push_byte;
        end
    end

`ifdef UART_ECHO_CRLF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lf_pend <= 1'b0;
        end else begin
            lf_pend <= push_ok && (push_byte == 8'h0D);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            state  <= state_nx;
            to_cnt <= to_cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        to_cnt_nx = to_cnt;
        unique case (state)
            IDLE: begin
                if (fifo_count != '0 && enable && !tx_busy) begin
                    state_nx = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nx  = WAIT_BUSY;
                to_cnt_nx = '0;
            end
            WAIT_BUSY: begin
                // A transmitter that never answers must not stall the
                // echo path forever; the byte is then treated as sent.
                if (tx_busy) begin
                    state_nx = WAIT_DONE;
                end else if (to_cnt == TO_LAST) begin
                    state_nx = IDLE;
                end else begin
                    to_cnt_nx = to_cnt + TO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    a_start_single: assert property (
        @(posedge clk) disable iff (rst) tx_start |=> !tx_start
    );

    a_count_range: assert property (
        @(posedge clk) disable iff (rst) fifo_count <= FULL_CNT
    );

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// tb_uart_echo_ctrl: directed and randomized checks of uart_echo_ctrl
// against a queue-based reference model; honours UART_ECHO_CRLF_EN.
module tb_uart_echo_ctrl;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int BT     = 16;
`ifdef UART_ECHO_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            tx_busy;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic [ADDR_W:0] fifo_count;
    logic            overflow;
    logic            overflow_clr;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;
    logic [7:0] txlog[$];

    always #5 clk = ~clk;

    uart_echo_ctrl #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_busy(tx_busy),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus a launch sequencer described by
    // elapsed time since the last launch.
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_start;
    bit         m_lf;
    logic [7:0] m_data;
    int         m_ph;      // 0 idle, 1 launching, 2 awaiting busy, 3 awaiting done
    longint     cyc = 0;
    longint     launch_cyc = 0;

    always @(posedge clk) begin
        bit         pop;
        bit         cand;
        bit         lost;
        bit         acc;
        logic [7:0] val;
        int         sz;
        int         nph;
        if (rst) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_start = 1'b0;
            m_lf    = 1'b0;
            m_data  = 8'h00;
            m_ph    = 0;
            armed   = 1'b1;
        end else begin
            sz  = mq.size();
            nph = m_ph;
            pop = (m_ph == 1);
            case (m_ph)
                0: if (sz > 0 && enable && !tx_busy) nph = 1;
                1: begin
                    nph = 2;
                    launch_cyc = cyc;
                end
                2: begin
                    if (tx_busy) nph = 3;
                    else if (cyc - launch_cyc == longint'(BT)) nph = 0;
                end
                default: if (!tx_busy) nph = 0;
            endcase
            m_start = pop;
            if (pop) m_data = mq.pop_front();
            cand = rx_valid;
            val  = rx_data;
            lost = 1'b0;
            if (CRLF && m_lf) begin
                cand = 1'b1;
                val  = 8'h0A;
                lost = rx_valid;
            end
            acc = cand && (mq.size() < DEPTH);
            if (acc) mq.push_back(val);
            m_lf = CRLF && acc && (val == 8'h0D);
            if ((cand && !acc) || lost) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
            m_ph = nph;
        end
        cyc++;
        #1;
        if (armed) begin
            chk("fifo_count", int'(fifo_count), mq.size());
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("tx_start", int'(tx_start), int'(m_start));
            chk("tx_data", int'(tx_data), int'(m_data));
            if (tx_start) txlog.push_back(tx_data);
        end
    end

    // Stimulus side: optional transmitter stand-in reacting to tx_start.
    bit auto_tx = 1'b0;
    int tx_dly  = -1;
    int tx_left = 0;

    task automatic tick();
        @(negedge clk);
        if (auto_tx) begin
            if (tx_busy) begin
                if (tx_left <= 1) tx_busy = 1'b0;
                else tx_left--;
            end else if (tx_dly == 0) begin
                tx_busy = 1'b1;
                tx_left = int'($urandom_range(1, 6));
                tx_dly  = -1;
            end else if (tx_dly > 0) begin
                tx_dly--;
            end
            if (tx_start && $urandom_range(0, 5) != 0)
                tx_dly = int'($urandom_range(0, 2));
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic settle();
        auto_tx = 1'b0;
        tx_dly  = -1;
        tx_busy = 1'b0;
        repeat (20) tick();
    endtask

    initial begin
        int base;
        int gap;
        rst          = 1'b1;
        enable       = 1'b1;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        tx_busy      = 1'b0;
        overflow_clr = 1'b0;

        repeat (3) tick();
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_start", int'(tx_start), 0);
        chk("rst_data", int'(tx_data), 0);
        rst = 1'b0;
        tick();

        // Single byte: launch two edges after the push edge.
        push(8'h41);
        chk("t1_count", int'(fifo_count), 1);
        chk("t1_start0", int'(tx_start), 0);
        tick();
        chk("t1_start1", int'(tx_start), 0);
        tick();
        chk("t1_start2", int'(tx_start), 1);
        chk("t1_data", int'(tx_data), 8'h41);
        chk("t1_count0", int'(fifo_count), 0);
        tx_busy = 1'b1;
        repeat (20) tick();
        tx_busy = 1'b0;
        repeat (3) tick();
        chk("t1_idle_start", int'(tx_start), 0);
        chk("t1_log", txlog.size(), 1);
        chk("t1_log0", int'(txlog[0]), 8'h41);

        // Burst while the transmitter is busy.
        base = txlog.size();
        tx_busy = 1'b1;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        chk("t2_count", int'(fifo_count), 3);
        tx_busy = 1'b0;
        tx_dly  = -1;
        auto_tx = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (txlog.size() >= base + 3 && fifo_count == 0) break;
            tick();
        end
        chk("t2_sent", txlog.size() - base, 3);
        for (int k = 0; k < 3; k++)
            if (txlog.size() > base + k)
                chk("t2_order", int'(txlog[base + k]), k + 1);
        settle();

        // Overflow with the transmitter held busy.
        base = txlog.size();
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
        chk("t3_count", int'(fifo_count), 4);
        chk("t3_ovf", int'(overflow), 1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("t3_clr", int'(overflow), 0);

        // Full FIFO, push exactly in the launch cycle.
        tx_busy = 1'b0;
        tick();
        push(8'h55);
        chk("t4_count", int'(fifo_count), 4);
        chk("t4_ovf", int'(overflow), 0);
        chk("t4_start", int'(tx_start), 1);
        chk("t4_data", int'(tx_data), 8'hA0);

        // Transmitter never answers: next launch after the timeout.
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!tx_start && gap < 40);
        chk("t5_gap", gap, BT + 2);
        chk("t5_data", int'(tx_data), 8'hA1);
        for (int i = 0; i < 300; i++) begin
            if (txlog.size() >= base + 5 && fifo_count == 0) break;
            tick();
        end
        settle();
        chk("t4_sent", txlog.size() - base, 5);
        if (txlog.size() >= base + 5) begin
            chk("t4_a3", int'(txlog[base + 3]), 8'hA3);
            chk("t4_last", int'(txlog[base + 4]), 8'h55);
        end

        // Carriage return handling.
        base = txlog.size();
        tx_busy = 1'b1;
        push(8'h0D);
        tick();
        chk("t6_count", int'(fifo_count), CRLF ? 2 : 1);
        tx_busy = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (fifo_count == 0) break;
            tick();
        end
        settle();
        chk("t6_sent", txlog.size() - base, CRLF ? 2 : 1);
        if (txlog.size() > base)
            chk("t6_cr", int'(txlog[base]), 8'h0D);

        // Randomized traffic against the model.
        tx_dly  = -1;
        auto_tx = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom);
            if ($urandom_range(0, 9) == 0) rx_data = 8'h0D;
            if ($urandom_range(0, 24) == 0) enable = ~enable;
            overflow_clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst          = 1'b0;
        rx_valid     = 1'b0;
        overflow_clr = 1'b0;
        enable       = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (fifo_count == 0) break;
            tick();
        end
        chk("drain", int'(fifo_count), 0);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
